alu_control_sequencer: RTL and testbench

- Multi-cycle control sequencer that drives the DataPath control bundle: register in/out enables, PC/IR/Y/Z/HI/LO/MAR/MDR strobes, Read and ALU_op.
- Runs instruction fetch (T0-T3), decodes the IR contents fed back from the datapath, then runs the execute steps for ALU-class instructions.
- Sits directly upstream of DataPath. It replaces the hand-driven control stimulus used in Phase 1 and turns the datapath into a self-stepping CPU core.

---
 rtl/alu_control_sequencer_pkg.sv | 69 ++++++
 rtl/alu_control_sequencer_reg_sel_decoder.sv | 20 ++
 rtl/alu_control_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_alu_control_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_control_sequencer_pkg.sv
// Shared encodings for the ALU control sequencer: ALU/opcode values, FSM states,
// IR field positions and the opcode classifier used by the execute steps.
package cpu_ctrl_pkg;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_MUL  = 5'd2;
  localparam logic [4:0] ALU_DIV  = 5'd3;
  localparam logic [4:0] ALU_SHR  = 5'd4;
  localparam logic [4:0] ALU_SHRA = 5'd5;
  localparam logic [4:0] ALU_SHL  = 5'd6;
  localparam logic [4:0] ALU_ROR  = 5'd7;
  localparam logic [4:0] ALU_ROL  = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;
  localparam logic [4:0] ALU_OR   = 5'd10;
  localparam logic [4:0] ALU_NEG  = 5'd11;
  localparam logic [4:0] ALU_NOT  = 5'd12;

  localparam logic [4:0] OP_NOP   = 5'd30;
  localparam logic [4:0] OP_HALT  = 5'd31;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 27;
  localparam int RA_MSB    = 26;
  localparam int RA_LSB    = 23;
  localparam int RB_MSB    = 22;
  localparam int RB_LSB    = 19;
  localparam int RC_MSB    = 18;
  localparam int RC_LSB    = 15;
  localparam int REG_IDX_W = 4;

  typedef enum logic [3:0] {
    IDLE,
    T0,
    T1,
    T2,
    T3,
    T4,
    T5,
    T6,
    T7,
    HALTED
  } state_e;

  typedef enum logic [2:0] {
    CLS_BINARY,
    CLS_UNARY,
    CLS_MULDIV,
    CLS_NOP,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_e;

  // Opcodes share the ALU encoding, so the class alone picks the execute sequence.
  function automatic op_class_e classify(input logic [4:0] opcode);
    op_class_e cls;
    case (opcode)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SHR,
      ALU_SHRA, ALU_SHL, ALU_ROR, ALU_ROL:  cls = CLS_BINARY;
      ALU_NEG, ALU_NOT:                     cls = CLS_UNARY;
      ALU_MUL, ALU_DIV:                     cls = CLS_MULDIV;
      OP_NOP:                               cls = CLS_NOP;
      OP_HALT:                              cls = CLS_HALT;
      default:                              cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/alu_control_sequencer_reg_sel_decoder.sv
// Register-select decoder: turns a register index field into a one-hot enable bus,
// all zeros when not enabled.
module reg_sel_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic                 en_i,
  input  logic [REG_IDX_W-1:0] sel_i,
  output logic [NUM_REGS-1:0]  onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int n = 0; n < NUM_REGS; n++) begin
      onehot_o[n] = en_i && (sel_i == REG_IDX_W'(n));
    end
  end

endmodule

// File: rtl/alu_control_sequencer.sv
// Multi-cycle control sequencer for the DataPath: fetch (T0-T3), decode in T4 and
// the execute steps for ALU-class instructions, with a bounded memory wait.
module alu_control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_REGS    = 16,
  parameter int DATA_W      = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   ir,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic                PCin,
  output logic                PCout,
  output logic                IncPC,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                HIin,
  output logic                LOin,
  output logic                MARin,
  output logic                MDRin,
  output logic                MDRout,
  output logic                Read,
  output logic                Zhighout,
  output logic                Zlowout,
  output logic [4:0]          ALU_op,
  output logic                busy,
  output logic                halted,
  output logic                instr_done,
  output logic                illegal_op,
  output logic                mem_error
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              memErr_q, memErr_d;

  logic [4:0]           opcode;
  logic [REG_IDX_W-1:0] fieldRa;
  logic [REG_IDX_W-1:0] fieldRb;
  logic [REG_IDX_W-1:0] fieldRc;
  op_class_e            opClass;
  logic                 unusedIr;

  logic                 rinEn;
  logic                 routEn;
  logic [REG_IDX_W-1:0] rinSel;
  logic [REG_IDX_W-1:0] routSel;

  assign opcode   = ir[OPC_MSB:OPC_LSB];
  assign fieldRa  = ir[RA_MSB:RA_LSB];
  assign fieldRb  = ir[RB_MSB:RB_LSB];
  assign fieldRc  = ir[RC_MSB:RC_LSB];
  assign opClass  = classify(opcode);
  assign unusedIr = ^ir[RC_LSB-1:0];

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      memErr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      memErr_q <= memErr_d;
    end
  end

  // The wait counter only advances while stalled in T2 and is zero everywhere else.
  always_comb begin
    state_d  = state_q;
    wait_d   = '0;
    memErr_d = memErr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = T0;
          memErr_d = 1'b0;
        end
      end
      T0: state_d = T1;
      T1: state_d = T2;
      T2: begin
        if (mem_ready) begin
          state_d = T3;
        end else if (wait_q == WAIT_LAST) begin
          state_d  = IDLE;
          memErr_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      T3: state_d = T4;
      T4: begin
        case (opClass)
          CLS_BINARY, CLS_UNARY, CLS_MULDIV: state_d = T5;
          CLS_HALT:                          state_d = HALTED;
          default:                           state_d = T0;
        endcase
      end
      T5: begin
        if (opClass == CLS_BINARY || opClass == CLS_MULDIV) begin
          state_d = T6;
        end else begin
          state_d = T0;
        end
      end
      T6: state_d = (opClass == CLS_MULDIV) ? T7 : T0;
      T7: state_d = T0;
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    PCin       = 1'b0;
    PCout      = 1'b0;
    IncPC      = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Zin        = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    MARin      = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    Read       = 1'b0;
    Zhighout   = 1'b0;
    Zlowout    = 1'b0;
    ALU_op     = ALU_ADD;
    busy       = 1'b1;
    halted     = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    rinEn      = 1'b0;
    rinSel     = fieldRa;
    routEn     = 1'b0;
    routSel    = fieldRb;
    case (state_q)
      IDLE: busy = 1'b0;
      HALTED: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
      end
      T2: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      T3: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T4: begin
        case (opClass)
          CLS_BINARY: begin
            routEn = 1'b1;
            Yin    = 1'b1;
          end
          CLS_UNARY: begin
            routEn = 1'b1;
            ALU_op = opcode;
            Zin    = 1'b1;
          end
          CLS_MULDIV: begin
            routEn  = 1'b1;
            routSel = fieldRa;
            Yin     = 1'b1;
          end
          CLS_NOP:     instr_done = 1'b1;
          CLS_ILLEGAL: illegal_op = 1'b1;
          default: ;
        endcase
      end
      T5: begin
        case (opClass)
          CLS_BINARY: begin
            routEn  = 1'b1;
            routSel = fieldRc;
            ALU_op  = opcode;
            Zin     = 1'b1;
          end
          CLS_MULDIV: begin
            routEn = 1'b1;
            ALU_op = opcode;
            Zin    = 1'b1;
          end
          CLS_UNARY: begin
            Zlowout    = 1'b1;
            rinEn      = 1'b1;
            instr_done = 1'b1;
          end
          default: ;
        endcase
      end
      T6: begin
        Zlowout = 1'b1;
        if (opClass == CLS_MULDIV) begin
          LOin = 1'b1;
        end else begin
          rinEn      = 1'b1;
          instr_done = 1'b1;
        end
      end
      T7: begin
        Zhighout   = 1'b1;
        HIin       = 1'b1;
        instr_done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  assign mem_error = memErr_q;

  reg_sel_decoder #(.NUM_REGS(NUM_REGS)) u_rinDecoder (
    .en_i     (rinEn),
    .sel_i    (rinSel),
    .onehot_o (Rin)
  );

  reg_sel_decoder #(.NUM_REGS(NUM_REGS)) u_routDecoder (
    .en_i     (routEn),
    .sel_i    (routSel),
    .onehot_o (Rout)
  );

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Self-checking bench for alu_control_sequencer: a step-list model of each instruction
// is compared cycle by cycle against the full control bundle.
module tb_alu_control_sequencer;

  localparam int TIMEOUT = 15;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic        mem_ready;
  logic [31:0] ir;
  logic [15:0] Rin, Rout;
  logic PCin, PCout, IncPC, IRin, Yin, Zin, HIin, LOin, MARin, MDRin, MDRout, Read, Zhighout, Zlowout;
  logic [4:0]  ALU_op;
  logic busy, halted, instr_done, illegal_op, mem_error;

  alu_control_sequencer #(.NUM_REGS(16), .DATA_W(32), .MEM_TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir(ir),
    .Rin(Rin), .Rout(Rout), .PCin(PCin), .PCout(PCout), .IncPC(IncPC), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .Read(Read), .Zhighout(Zhighout), .Zlowout(Zlowout), .ALU_op(ALU_op),
    .busy(busy), .halted(halted), .instr_done(instr_done), .illegal_op(illegal_op),
    .mem_error(mem_error)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic pcIn, pcOut, incPc, irIn, yIn, zIn, hiIn, loIn, marIn, mdrIn, mdrOut, read, zHighOut, zLowOut;
    logic [4:0] aluOp;
    logic busy, halted, done, illegal, memErr;
  } ctrl_t;

  ctrl_t obs;
  assign obs = {Rin, Rout, PCin, PCout, IncPC, IRin, Yin, Zin, HIin, LOin, MARin, MDRin,
                MDRout, Read, Zhighout, Zlowout, ALU_op, busy, halted, instr_done, illegal_op, mem_error};

  int    checks = 0;
  int    fails  = 0;
  ctrl_t expQ[$];
  bit    memQ[$];
  bit    modelMemErr = 1'b0;

  function automatic logic [15:0] oneHot(input logic [3:0] idx);
    return 16'(1) << idx;
  endfunction

  function automatic ctrl_t busyStep();
    ctrl_t s = '0;
    s.busy = 1'b1;
    return s;
  endfunction

  function automatic ctrl_t idleStep();
    ctrl_t s = '0;
    s.memErr = modelMemErr;
    return s;
  endfunction

  function automatic void push(input ctrl_t s, input bit m);
    expQ.push_back(s);
    memQ.push_back(m);
  endfunction

  // Fetch: T0, T1, the T2 memory wait (waits stalls then ready, or a full timeout), T3.
  function automatic void modelFetch(input int waits, input bit timeout);
    ctrl_t s;
    int    t2Cycles = timeout ? TIMEOUT : waits + 1;
    s = busyStep(); s.pcOut = 1; s.marIn = 1; s.incPc = 1; s.zIn = 1;
    push(s, 1'($urandom_range(0, 1)));
    s = busyStep(); s.zLowOut = 1; s.pcIn = 1;
    push(s, 1'($urandom_range(0, 1)));
    for (int i = 0; i < t2Cycles; i++) begin
      s = busyStep(); s.read = 1; s.mdrIn = 1;
      push(s, !timeout && (i == waits));
    end
    if (!timeout) begin
      s = busyStep(); s.mdrOut = 1; s.irIn = 1;
      push(s, 1'($urandom_range(0, 1)));
    end
  endfunction

  // Execute steps from T4 onward, chosen from the instruction's opcode.
  function automatic void modelExec(input logic [4:0] op, input logic [3:0] ra,
                                    input logic [3:0] rb, input logic [3:0] rc);
    ctrl_t s;
    if (op inside {5'd0, 5'd1, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10}) begin
      s = busyStep(); s.rout = oneHot(rb); s.yIn = 1; push(s, 1'b1);
      s = busyStep(); s.rout = oneHot(rc); s.aluOp = op; s.zIn = 1; push(s, 1'b0);
      s = busyStep(); s.zLowOut = 1; s.rin = oneHot(ra); s.done = 1; push(s, 1'b1);
    end else if (op == 5'd11 || op == 5'd12) begin
      s = busyStep(); s.rout = oneHot(rb); s.aluOp = op; s.zIn = 1; push(s, 1'b0);
      s = busyStep(); s.zLowOut = 1; s.rin = oneHot(ra); s.done = 1; push(s, 1'b1);
    end else if (op == 5'd2 || op == 5'd3) begin
      s = busyStep(); s.rout = oneHot(ra); s.yIn = 1; push(s, 1'b1);
      s = busyStep(); s.rout = oneHot(rb); s.aluOp = op; s.zIn = 1; push(s, 1'b0);
      s = busyStep(); s.zLowOut = 1; s.loIn = 1; push(s, 1'b1);
      s = busyStep(); s.zHighOut = 1; s.hiIn = 1; s.done = 1; push(s, 1'b0);
    end else if (op == 5'd30) begin
      s = busyStep(); s.done = 1; push(s, 1'b1);
    end else if (op == 5'd31) begin
      s = busyStep(); push(s, 1'b1);
    end else begin
      s = busyStep(); s.illegal = 1; push(s, 1'b0);
    end
  endfunction

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic applyClear();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1; start = 1'b1; mem_ready = 1'b0; ir = '0;
    repeat (2) @(negedge clock);
    checks++;
    if (obs !== idleStep()) begin
      fails++; $display("[TB] FAIL reset_state: got %h expected %h", obs, idleStep());
    end
    clear = 1'b0; start = 1'b0;
    @(negedge clock);
    checks++;
    if (obs !== idleStep()) begin
      fails++; $display("[TB] FAIL reset_idle_hold: got %h expected %h", obs, idleStep());
    end
  endtask

  task automatic test_add();
    ctrl_t e;
    int    k = 0;
    pulseStart();
    ir = 32'h00D10000;
    modelFetch(0, 0);
    modelExec(5'd0, 4'd1, 4'd10, 4'd2);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); mem_ready = memQ.pop_front();
      checks++;
      if (obs !== e) begin
        fails++; $display("[TB] FAIL add step %0d: got %h expected %h", k, obs, e);
      end
      k++;
      @(negedge clock);
    end
  endtask

  task automatic test_mul();
    ctrl_t e;
    int    k = 0;
    ir = 32'h11980000;
    modelFetch(0, 0);
    modelExec(5'd2, 4'd3, 4'd3, 4'd0);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); mem_ready = memQ.pop_front();
      checks++;
      if (obs !== e) begin
        fails++; $display("[TB] FAIL mul step %0d: got %h expected %h", k, obs, e);
      end
      k++;
      @(negedge clock);
    end
  endtask

  task automatic test_mem_wait();
    ctrl_t e;
    int    k = 0;
    int    readCycles = 0;
    ir = {5'd10, 4'd4, 4'd5, 4'd6, 15'h1234};
    modelFetch(3, 0);
    modelExec(5'd10, 4'd4, 4'd5, 4'd6);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); mem_ready = memQ.pop_front();
      if (Read) readCycles++;
      checks++;
      if (obs !== e) begin
        fails++; $display("[TB] FAIL mem_wait step %0d: got %h expected %h", k, obs, e);
      end
      k++;
      @(negedge clock);
    end
    checks++;
    if (readCycles != 4) begin
      fails++; $display("[TB] FAIL mem_wait_read_cycles: got %0d expected 4", readCycles);
    end
  endtask

  task automatic test_illegal_halt();
    ctrl_t e;
    ctrl_t h;
    int    k = 0;
    ir = {5'd20, 4'd7, 4'd8, 4'd9, 15'h0};
    modelFetch(1, 0);
    modelExec(5'd20, 4'd7, 4'd8, 4'd9);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); mem_ready = memQ.pop_front();
      checks++;
      if (obs !== e) begin
        fails++; $display("[TB] FAIL illegal step %0d: got %h expected %h", k, obs, e);
      end
      k++;
      @(negedge clock);
    end
    ir = {5'd31, 4'd2, 4'd2, 4'd2, 15'h0};
    modelFetch(0, 0);
    modelExec(5'd31, 4'd2, 4'd2, 4'd2);
    k = 0;
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); mem_ready = memQ.pop_front();
      checks++;
      if (obs !== e) begin
        fails++; $display("[TB] FAIL halt step %0d: got %h expected %h", k, obs, e);
      end
      k++;
      @(negedge clock);
    end
    h = '0; h.halted = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== h) begin
        fails++; $display("[TB] FAIL halted_hold cycle %0d: got %h expected %h", i, obs, h);
      end
      start = 1'($urandom_range(0, 1)); mem_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    start = 1'b0;
    applyClear();
    checks++;
    if (obs !== idleStep()) begin
      fails++; $display("[TB] FAIL halt_clear_exit: got %h expected %h", obs, idleStep());
    end
  endtask

  task automatic test_timeout();
    ctrl_t e;
    int    k = 0;
    pulseStart();
    ir = {5'd30, 4'd0, 4'd0, 4'd0, 15'h0};
    modelFetch(0, 1);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); void'(memQ.pop_front());
      mem_ready = 1'b0;
      checks++;
      if (obs !== e) begin
        fails++; $display("[TB] FAIL timeout step %0d: got %h expected %h", k, obs, e);
      end
      k++;
      @(negedge clock);
    end
    modelMemErr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs !== idleStep()) begin
        fails++; $display("[TB] FAIL timeout_idle cycle %0d: got %h expected %h", i, obs, idleStep());
      end
      @(negedge clock);
    end
    pulseStart();
    modelMemErr = 1'b0;
    modelFetch(0, 0);
    modelExec(5'd30, 4'd0, 4'd0, 4'd0);
    k = 0;
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); mem_ready = memQ.pop_front();
      checks++;
      if (obs !== e) begin
        fails++; $display("[TB] FAIL timeout_restart step %0d: got %h expected %h", k, obs, e);
      end
      k++;
      @(negedge clock);
    end
    applyClear();
  endtask

  task automatic test_clear_mid();
    ctrl_t e;
    pulseStart();
    ir = {5'd1, 4'd5, 4'd6, 4'd7, 15'h0};
    modelFetch(0, 0);
    modelExec(5'd1, 4'd5, 4'd6, 4'd7);
    for (int k = 0; k < 6; k++) begin
      e = expQ.pop_front(); mem_ready = memQ.pop_front();
      checks++;
      if (obs !== e) begin
        fails++; $display("[TB] FAIL clear_mid step %0d: got %h expected %h", k, obs, e);
      end
      if (k == 5) begin
        clear = 1'b1; start = 1'b1;
      end
      @(negedge clock);
    end
    expQ.delete(); memQ.delete();
    clear = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs !== idleStep()) begin
        fails++; $display("[TB] FAIL clear_mid_idle cycle %0d: got %h expected %h", i, obs, idleStep());
      end
      @(negedge clock);
    end
  endtask

  task automatic test_random();
    ctrl_t       e;
    logic [4:0]  op;
    logic [3:0]  ra, rb, rc;
    int          r;
    int          k;
    applyClear();
    pulseStart();
    for (int n = 0; n < 24; n++) begin
      r = $urandom_range(0, 15);
      if (r <= 12) op = 5'(r);
      else if (r == 13) op = 5'd30;
      else op = 5'($urandom_range(13, 29));
      ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom);
      ir = {op, ra, rb, rc, 15'($urandom)};
      modelFetch($urandom_range(0, 4), 0);
      modelExec(op, ra, rb, rc);
      k = 0;
      while (expQ.size() > 0) begin
        e = expQ.pop_front(); mem_ready = memQ.pop_front();
        checks++;
        if (obs !== e) begin
          fails++; $display("[TB] FAIL random instr %0d op %0d step %0d: got %h expected %h", n, op, k, obs, e);
        end
        k++;
        @(negedge clock);
      end
    end
    applyClear();
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; mem_ready = 1'b0; ir = '0;
    test_reset();
    test_add();
    test_mul();
    test_mem_wait();
    test_illegal_halt();
    test_timeout();
    test_clear_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
